// File: rtl/uart_tx_fifo_ctrl.sv
// Read-side sequencer: pops one byte at a time from the UART FIFO and hands it to the transmitter.
// Optional inter-frame idle spacing is compiled in when TX_GAP_EN is defined.
module uart_tx_fifo_ctrl #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 16
) (
  input  logic              rd_clk,
  input  logic              rd_reset,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              ctrl_busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    START,
    WAIT_ACK,
    WAIT_DONE
`ifdef TX_GAP_EN
    , GAP
`endif
  } state_t;

  state_t state_reg, state_next;
  logic   frame_done;

`ifdef TX_GAP_EN
  // A zero gap still spends one cycle in GAP, so the last count is clamped at 0.
  localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST_V = GAP_LAST[GAP_W-1:0];

  logic [GAP_W-1:0] gap_cnt_reg;

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      gap_cnt_reg <= '0;
    end else if (state_reg == GAP) begin
      gap_cnt_reg <= gap_cnt_reg + 1'b1;
    end else begin
      gap_cnt_reg <= '0;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tx_enable && !fifo_empty && !tx_busy) state_next = FETCH;
      end
      FETCH:    state_next = CAPTURE;
      CAPTURE:  state_next = START;
      START:    state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          frame_done = 1'b1;
`ifdef TX_GAP_EN
          state_next = GAP;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef TX_GAP_EN
      GAP: begin
        if (gap_cnt_reg == GAP_LAST_V) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output comes straight from a flop.
  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      state_reg  <= IDLE;
      fifo_rd_en <= 1'b0;
      tx_start   <= 1'b0;
      ctrl_busy  <= 1'b0;
      tx_data    <= '0;
      frame_cnt  <= '0;
    end else begin
      state_reg  <= state_next;
      fifo_rd_en <= (state_next == FETCH);
      tx_start   <= (state_next == START);
      ctrl_busy  <= (state_next != IDLE);
      if (state_reg == CAPTURE) tx_data <= fifo_rd_data;
      if (frame_done) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl with a FIFO model and a transmitter model (busy for 10 cycles).
// Frame spacing expectation follows TX_GAP_EN (GAP_CYCLES=5 here).
module tb_uart_tx_fifo_ctrl;
  localparam int DW       = 8;
  localparam int CW       = 4;
  localparam int GC       = 5;
  localparam int BUSY_LEN = 10;
`ifdef TX_GAP_EN
  localparam int EXP_SPACING = 7;
`else
  localparam int EXP_SPACING = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_enable = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          tx_busy = 1'b0;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          ctrl_busy;
  logic [CW-1:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo_ctrl #(.DATA_W(DW), .CNT_W(CW), .GAP_CYCLES(GC)) dut (
    .rd_clk(clk), .rd_reset(rst), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .ctrl_busy(ctrl_busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read, data valid the cycle after the strobe
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && rd_ptr < wr_ptr) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Transmitter model: busy for BUSY_LEN cycles after a start; hold_ack delays the response
  bit hold_ack = 1'b0;
  bit pending  = 1'b0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) pending <= 1'b1;
    if (tx_busy) begin
      if (busy_cnt == 1) tx_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end else if ((pending || tx_start) && !hold_ack) begin
      tx_busy  <= 1'b1;
      busy_cnt <= BUSY_LEN;
      pending  <= 1'b0;
    end
  end

  // Monitor
  int cyc = 0;
  int rd_pulses = 0;
  int start_pulses = 0;
  int fall_cyc = 0;
  logic prev_busy = 1'b0;
  logic [DW-1:0] sent [$];
  int spacing [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    prev_busy = tx_busy;
    if (fifo_rd_en) begin
      rd_pulses = rd_pulses + 1;
      spacing.push_back(cyc - fall_cyc);
    end
    if (tx_start) begin
      start_pulses = start_pulses + 1;
      sent.push_back(tx_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int r0, s0, q0, p0;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ctrl_busy", ctrl_busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    cycles(2);

    // Reset asserted during START: outputs clear immediately, byte is lost
    push(8'h3C);
    tx_enable = 1'b1;
    for (int i = 0; i < 20 && !tx_start; i++) @(negedge clk);
    check("mid_start_seen", tx_start, 1);
    check("mid_start_data", tx_data, 8'h3C);
    rst = 1'b1;
    #1;
    check("async_rst_tx_start", tx_start, 0);
    check("async_rst_tx_data", tx_data, 0);
    check("async_rst_ctrl_busy", ctrl_busy, 0);
    @(negedge clk);
    tx_enable = 1'b0;
    rst = 1'b0;
    cycles(20);
    check("post_rst_idle", ctrl_busy, 0);
    check("post_rst_frame_cnt", frame_cnt, 0);

    // Single byte with exact strobe sequencing
    push(8'hA5);
    tx_enable = 1'b1;
    for (int i = 0; i < 20 && !fifo_rd_en; i++) @(negedge clk);
    check("single_rd_en", fifo_rd_en, 1);
    @(negedge clk);
    check("single_rd_en_width", fifo_rd_en, 0);
    check("single_capture_no_start", tx_start, 0);
    @(negedge clk);
    check("single_tx_start", tx_start, 1);
    check("single_tx_data", tx_data, 8'hA5);
    @(negedge clk);
    check("single_tx_start_width", tx_start, 0);
    for (int i = 0; i < 100 && ctrl_busy; i++) @(negedge clk);
    check("single_done_ctrl_busy", ctrl_busy, 0);
    check("single_frame_cnt", frame_cnt, 1);
    check("single_hold_data", tx_data, 8'hA5);

    // Burst of four
    r0 = rd_pulses; s0 = start_pulses; q0 = sent.size(); p0 = spacing.size();
    for (int i = 1; i <= 4; i++) push(8'(i));
    @(negedge clk);
    for (int i = 0; i < 400 && (rd_ptr != wr_ptr || ctrl_busy); i++) @(negedge clk);
    check("burst_rd_pulses", rd_pulses - r0, 4);
    check("burst_start_pulses", start_pulses - s0, 4);
    check("burst_frame_cnt", frame_cnt, 5);
    for (int i = 0; i < 4; i++) begin
      if (sent.size() > q0 + i) check($sformatf("burst_data%0d", i), sent[q0 + i], i + 1);
      else check($sformatf("burst_data%0d_missing", i), 32'hFFFF_FFFF, i + 1);
    end
    for (int i = 1; i < 4; i++) begin
      if (spacing.size() > p0 + i) check($sformatf("burst_spacing%0d", i), spacing[p0 + i], EXP_SPACING);
      else check($sformatf("burst_spacing%0d_missing", i), 32'hFFFF_FFFF, EXP_SPACING);
    end

    // Empty FIFO, then disabled with data present
    r0 = rd_pulses; s0 = start_pulses;
    cycles(100);
    check("empty_rd_pulses", rd_pulses - r0, 0);
    check("empty_start_pulses", start_pulses - s0, 0);
    tx_enable = 1'b0;
    push(8'h77);
    push(8'h88);
    cycles(100);
    check("disabled_rd_pulses", rd_pulses - r0, 0);
    check("disabled_start_pulses", start_pulses - s0, 0);
    check("disabled_ctrl_busy", ctrl_busy, 0);

    // tx_enable dropped during WAIT_ACK: frame completes, no further fetch
    hold_ack = 1'b1;
    tx_enable = 1'b1;
    for (int i = 0; i < 50 && !tx_start; i++) @(negedge clk);
    check("drop_tx_start", tx_start, 1);
    @(negedge clk);
    tx_enable = 1'b0;
    cycles(5);
    check("drop_wait_ack_busy", ctrl_busy, 1);
    hold_ack = 1'b0;
    for (int i = 0; i < 100 && ctrl_busy; i++) @(negedge clk);
    cycles(30);
    check("drop_frame_cnt", frame_cnt, 6);
    check("drop_rd_pulses", rd_pulses - r0, 1);
    check("drop_start_pulses", start_pulses - s0, 1);
    check("drop_data", sent[sent.size() - 1], 8'h77);
    check("drop_fifo_left", wr_ptr - rd_ptr, 1);

    // Counter wrap: 17 frames from reset with a 4-bit counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("wrap_rst_cnt", frame_cnt, 0);
    s0 = start_pulses;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    tx_enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1500 && (rd_ptr != wr_ptr || ctrl_busy); i++) @(negedge clk);
    check("wrap_start_pulses", start_pulses - s0, 17);
    check("wrap_frame_cnt", frame_cnt, 1);
    check("wrap_last_data", sent[sent.size() - 1], 8'h1F);
    check("wrap_idle", ctrl_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
